// File: rtl/dds_pkg.sv
// Shared constants for the multichannel DDS core: waveform modes,
// config register addresses and the DUTY reset value.
package dds_pkg;

  typedef enum logic [1:0] {
    MODE_SINE = 2'b00,
    MODE_RECT = 2'b01,
    MODE_TRI  = 2'b10,
    MODE_PWM  = 2'b11
  } modeT;

  localparam logic [1:0] ADDR_STEP  = 2'd0;
  localparam logic [1:0] ADDR_PHASE = 2'd1;
  localparam logic [1:0] ADDR_DUTY  = 2'd2;
  localparam logic [1:0] ADDR_CTRL  = 2'd3;

  // DUTY resets to half scale (50 % PWM) for any accumulator width
  function automatic logic [63:0] dutyResetValue(input int accW);
    return 64'd1 << (accW - 1);
  endfunction

endpackage

// File: rtl/dds_sine_lut.sv
// Quarter-wave sine ROM: 2^LUT_AW+1 unsigned magnitudes from 0 to
// 2^(OUT_W-1)-1, filled at elaboration from a Taylor series.
module dds_sine_lut #(
  parameter int LUT_AW = 8,
  parameter int OUT_W  = 16
) (
  input  logic [LUT_AW:0]  addr,
  output logic [OUT_W-1:0] mag
);

  localparam int DEPTH = (1 << LUT_AW) + 1;

  // round((2^(OUT_W-1)-1) * sin(pi*i / 2^(LUT_AW+1))); only +,*,/ on reals so
  // elaboration needs no math library
  function automatic logic [OUT_W-1:0] lutEntry(input int i);
    real x, term, sum, amp;
    x    = 3.14159265358979323846 * real'(i) / real'(2 ** (LUT_AW + 1));
    term = x;
    sum  = x;
    for (int n = 1; n <= 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    amp = real'((2 ** (OUT_W - 1)) - 1);
    return OUT_W'($rtoi(amp * sum + 0.5));
  endfunction

  logic [OUT_W-1:0] rom [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : gRom
    assign rom[i] = lutEntry(i);
  end

  assign mag = rom[addr];

endmodule

// File: rtl/dds_multichannel_core.sv
// NUM_CH DDS channels with shadowed configuration applied by a global commit,
// a two-stage sample pipeline per channel and one packed output bus.
module dds_multichannel_core
  import dds_pkg::*;
#(
  parameter int  NUM_CH = 2,
  parameter int  ACC_W  = 32,
  parameter int  OUT_W  = 16,
  parameter int  LUT_AW = 8,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_we,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [1:0]              cfg_addr,
  input  logic [ACC_W-1:0]        cfg_wdata,
  input  logic                    commit,
  input  logic                    sync_clr,
  output logic                    commit_ack,
  output logic                    out_valid,
  output logic [NUM_CH*OUT_W-1:0] wave_out
);

  localparam logic [ACC_W-1:0]        DUTY_RST = ACC_W'(dutyResetValue(ACC_W));
  localparam logic [OUT_W-1:0]        MID      = {1'b1, {(OUT_W - 1){1'b0}}};
  localparam logic signed [OUT_W+1:0] MID_W    = {2'b00, MID};
  localparam logic signed [OUT_W+1:0] MAX_W    = {2'b00, {OUT_W{1'b1}}};
  localparam logic [LUT_AW:0]         QUARTER  = {1'b1, {LUT_AW{1'b0}}};

  logic [ACC_W-1:0] shStep [NUM_CH], shOfs [NUM_CH], shDuty [NUM_CH];
  logic [ACC_W-1:0] nxStep [NUM_CH], nxOfs [NUM_CH], nxDuty [NUM_CH];
  logic [ACC_W-1:0] acStep [NUM_CH], acOfs [NUM_CH], acDuty [NUM_CH];
  modeT             shMode [NUM_CH], nxMode [NUM_CH], acMode [NUM_CH];
  logic             shEn   [NUM_CH], nxEn   [NUM_CH], acEn   [NUM_CH];

  logic [ACC_W-1:0] acc    [NUM_CH];
  logic [ACC_W-1:0] ph     [NUM_CH];
  logic [ACC_W-1:0] phDuty [NUM_CH];
  modeT             phMode [NUM_CH];
  logic             phEn   [NUM_CH];

  logic [NUM_CH*OUT_W-1:0] sampleAll;
  logic [1:0]              validPipe;

  // Shadow contents with this cycle's write folded in; commit copies this view
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      // NOTE: defaults first so a channel without a write keeps its value instead of inferring a latch
      nxStep[c] = shStep[c];
      nxOfs[c]  = shOfs[c];
      nxDuty[c] = shDuty[c];
      nxMode[c] = shMode[c];
      nxEn[c]   = shEn[c];
      if (cfg_we && cfg_ch == CH_W'(c)) begin
        unique case (cfg_addr)
          ADDR_STEP:  nxStep[c] = cfg_wdata;
          ADDR_PHASE: nxOfs[c]  = cfg_wdata;
          ADDR_DUTY:  nxDuty[c] = cfg_wdata;
          ADDR_CTRL: begin
            nxMode[c] = modeT'(cfg_wdata[1:0]);
            nxEn[c]   = cfg_wdata[2];
          end
        endcase
      end
    end
  end

  // Shadow registers track every write; active registers load on commit
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: these per-channel arrays are a few flops each, not RAM, so they reset like any register
      for (int c = 0; c < NUM_CH; c++) begin
        shStep[c] <= '0;
        shOfs[c]  <= '0;
        shDuty[c] <= DUTY_RST;
        shMode[c] <= MODE_SINE;
        shEn[c]   <= 1'b1;
        acStep[c] <= '0;
        acOfs[c]  <= '0;
        acDuty[c] <= DUTY_RST;
        acMode[c] <= MODE_SINE;
        acEn[c]   <= 1'b1;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        // NOTE: non-blocking so every register samples pre-edge values regardless of statement order
        shStep[c] <= nxStep[c];
        shOfs[c]  <= nxOfs[c];
        shDuty[c] <= nxDuty[c];
        shMode[c] <= nxMode[c];
        shEn[c]   <= nxEn[c];
        if (commit) begin
          acStep[c] <= nxStep[c];
          acOfs[c]  <= nxOfs[c];
          acDuty[c] <= nxDuty[c];
          acMode[c] <= nxMode[c];
          acEn[c]   <= nxEn[c];
        end
      end
    end
  end

  // Phase accumulators: wrap silently, cleared together by sync_clr, parked at 0 when disabled
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (sync_clr || !acEn[c]) acc[c] <= '0;
        else                      acc[c] <= acc[c] + acStep[c];
      end
    end
  end

  // Stage S1: offset phase, with the settings that shape it carried alongside
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        ph[c]     <= '0;
        phDuty[c] <= DUTY_RST;
        phMode[c] <= MODE_SINE;
        phEn[c]   <= 1'b1;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        ph[c]     <= acc[c] + acOfs[c];
        phDuty[c] <= acDuty[c];
        phMode[c] <= acMode[c];
        phEn[c]   <= acEn[c];
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : gCh
    logic [1:0]              quad;
    logic [LUT_AW-1:0]       idx;
    logic [LUT_AW:0]         lutAddr;
    logic [OUT_W-1:0]        mag;
    logic [OUT_W-1:0]        sineVal;
    logic [OUT_W-1:0]        sample;
    logic [OUT_W:0]          triT;
    logic signed [OUT_W+1:0] sineWide;

    assign quad    = ph[c][ACC_W-1 -: 2];
    assign idx     = ph[c][ACC_W-3 -: LUT_AW];
    assign lutAddr = quad[0] ? (QUARTER - {1'b0, idx}) : {1'b0, idx};
    assign triT    = ph[c][ACC_W-1 -: OUT_W+1];

    dds_sine_lut #(.LUT_AW(LUT_AW), .OUT_W(OUT_W)) uLut (
      .addr(lutAddr),
      .mag (mag)
    );

    // Fold the quarter-wave magnitude about midscale and clamp to the output range
    always_comb begin
      sineWide = quad[1] ? (MID_W - $signed({2'b00, mag})) : (MID_W + $signed({2'b00, mag}));
      sineVal  = sineWide[OUT_W-1:0];
      if (sineWide < 0)          sineVal = '0;
      else if (sineWide > MAX_W) sineVal = '1;
    end

    // Stage S2 waveform select; a disabled channel sits at midscale
    always_comb begin
      sample = MID;
      if (phEn[c]) begin
        unique case (phMode[c])
          MODE_SINE: sample = sineVal;
          MODE_RECT: sample = ph[c][ACC_W-1] ? '0 : '1;
          MODE_TRI:  sample = triT[OUT_W] ? ~triT[OUT_W-1:0] : triT[OUT_W-1:0];
          MODE_PWM:  sample = (ph[c] < phDuty[c]) ? '1 : '0;
        endcase
      end
    end

    assign sampleAll[c*OUT_W +: OUT_W] = sample;
  end

  // Stage S2 output register, pipeline-valid tracking and commit acknowledge
  always_ff @(posedge clk) begin
    if (!reset) begin
      wave_out   <= '0;
      validPipe  <= '0;
      commit_ack <= 1'b0;
    end else begin
      wave_out   <= sampleAll;
      validPipe  <= {validPipe[0], 1'b1};
      commit_ack <= commit;
    end
  end

  assign out_valid = validPipe[1];

endmodule

// File: tb/tb_dds_multichannel_core.sv
// Self-checking bench for dds_multichannel_core: a vector table for the
// directed scenarios, hand sequences for multi-cycle corners and random
// traffic, all cross-checked every cycle against a behavioural model.
module tb_dds_multichannel_core;
  import dds_pkg::*;

  localparam int NUM_CH = 3;
  localparam int ACC_W  = 32;
  localparam int OUT_W  = 16;
  localparam int LUT_AW = 8;

  logic                    clk = 1'b0;
  logic                    rstN;
  logic                    cfgWe;
  logic [1:0]              cfgCh;
  logic [1:0]              cfgAddr;
  logic [ACC_W-1:0]        cfgData;
  logic                    commitIn;
  logic                    syncClr;
  logic                    commitAck;
  logic                    outValid;
  logic [NUM_CH*OUT_W-1:0] waveOut;

  dds_multichannel_core #(
    .NUM_CH(NUM_CH), .ACC_W(ACC_W), .OUT_W(OUT_W), .LUT_AW(LUT_AW)
  ) dut (
    .clk       (clk),
    .reset     (rstN),
    .cfg_we    (cfgWe),
    .cfg_ch    (cfgCh),
    .cfg_addr  (cfgAddr),
    .cfg_wdata (cfgData),
    .commit    (commitIn),
    .sync_clr  (syncClr),
    .commit_ack(commitAck),
    .out_valid (outValid),
    .wave_out  (waveOut)
  );

  always #5 clk = ~clk;

  int passCnt  = 0;
  int totalCnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  bit [31:0] sStep [NUM_CH], sOfs [NUM_CH], sDuty [NUM_CH];
  bit [31:0] aStep [NUM_CH], aOfs [NUM_CH], aDuty [NUM_CH];
  int        sMode [NUM_CH], aMode [NUM_CH];
  bit        sEn   [NUM_CH], aEn   [NUM_CH];
  bit [31:0] mAcc  [NUM_CH];
  int        mPend [NUM_CH];
  int        expWave [NUM_CH];
  bit        expValid, expAck;
  int        vCnt;

  function automatic int lutRef(input int i);
    return $rtoi(32767.0 * $sin(3.14159265358979323846 * real'(i) / 512.0) + 0.5);
  endfunction

  function automatic int refSample(input bit [31:0] p, input int mode, input bit [31:0] duty, input bit en);
    int q, k, m, t, v;
    if (!en) return 32768;
    case (mode)
      0: begin
        q = int'(p >> 30);
        k = int'((p >> 22) & 32'hFF);
        m = lutRef((q % 2 == 1) ? 256 - k : k);
        v = (q < 2) ? 32768 + m : 32768 - m;
        if (v < 0) v = 0;
        if (v > 65535) v = 65535;
        return v;
      end
      1: return (p < 32'h8000_0000) ? 65535 : 0;
      2: begin
        t = int'(p >> 15);
        return (t < 65536) ? t : 131071 - t;
      end
      default: return (p < duty) ? 65535 : 0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently driven
  task automatic modelEdge();
    if (!rstN) begin
      for (int c = 0; c < NUM_CH; c++) begin
        sStep[c] = 0; sOfs[c] = 0; sDuty[c] = 32'h8000_0000; sMode[c] = 0; sEn[c] = 1;
        aStep[c] = 0; aOfs[c] = 0; aDuty[c] = 32'h8000_0000; aMode[c] = 0; aEn[c] = 1;
        mAcc[c] = 0;
        expWave[c] = 0;
        mPend[c] = refSample(0, 0, 32'h8000_0000, 1);
      end
      expAck = 0; expValid = 0; vCnt = 0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        expWave[c] = mPend[c];
        mPend[c]   = refSample(mAcc[c] + aOfs[c], aMode[c], aDuty[c], aEn[c]);
        mAcc[c]    = (syncClr || !aEn[c]) ? 32'd0 : mAcc[c] + aStep[c];
      end
      if (cfgWe && int'(cfgCh) < NUM_CH) begin
        case (cfgAddr)
          2'd0: sStep[cfgCh] = cfgData;
          2'd1: sOfs[cfgCh]  = cfgData;
          2'd2: sDuty[cfgCh] = cfgData;
          default: begin
            sMode[cfgCh] = int'(cfgData[1:0]);
            sEn[cfgCh]   = cfgData[2];
          end
        endcase
      end
      if (commitIn) begin
        aStep = sStep; aOfs = sOfs; aDuty = sDuty; aMode = sMode; aEn = sEn;
      end
      expAck = commitIn;
      if (vCnt < 2) vCnt++;
      expValid = (vCnt == 2);
    end
  endtask

  task automatic compareAll();
    check("out_valid", 64'(outValid), 64'(expValid));
    check("commit_ack", 64'(commitAck), 64'(expAck));
    for (int c = 0; c < NUM_CH; c++)
      check($sformatf("model wave ch%0d", c), 64'(waveOut[c*OUT_W +: OUT_W]), 64'(expWave[c]));
  endtask

  task automatic cycle();
    @(posedge clk);
    modelEdge();
    #1;
    compareAll();
  endtask

  task automatic drive(input bit we, input int ch, input logic [1:0] addr, input bit [31:0] d,
                       input bit cm, input bit clr, input bit r);
    cfgWe = we; cfgCh = 2'(ch); cfgAddr = addr; cfgData = d;
    commitIn = cm; syncClr = clr; rstN = r;
  endtask

  task automatic idle();
    drive(0, 0, 2'd0, 0, 0, 0, 1);
  endtask

  function automatic int chWave(input int c);
    return int'(waveOut[c*OUT_W +: OUT_W]);
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    bit        we;
    int        ch;
    bit [1:0]  addr;
    bit [31:0] data;
    bit        cm;
    bit        clr;
    bit        rst;
    int        chk;     // channel to compare, -1 = none
    int        exp;
    int        expAck;  // -1 = don't compare
  } vecT;

  function automatic vecT mk(input bit we, input int ch, input bit [1:0] addr, input bit [31:0] d,
                             input bit cm, input bit clr, input bit r, input int chk, input int ex,
                             input int ack);
    vecT v;
    v.we = we; v.ch = ch; v.addr = addr; v.data = d; v.cm = cm; v.clr = clr; v.rst = r;
    v.chk = chk; v.exp = ex; v.expAck = ack;
    return v;
  endfunction

  vecT vt [32];
  int  cnt;
  int  sineSeq [4];

  initial begin
    vt[0]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 'h0000, 0);
    vt[1]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 'h0000, 0);
    vt[2]  = mk(0, 0, 0, 0, 0, 0, 1, -1, 0, 0);
    vt[3]  = mk(0, 0, 0, 0, 0, 0, 1,  0, 'h8000, 0);
    vt[4]  = mk(0, 0, 0, 0, 0, 0, 1,  0, 'h8000, 0);
    vt[5]  = mk(0, 0, 0, 0, 0, 0, 1,  1, 'h8000, 0);
    vt[6]  = mk(1, 0, ADDR_STEP, 32'h4000_0000, 0, 0, 1, 0, 'h8000, 0);
    vt[7]  = mk(1, 0, ADDR_CTRL, 32'h5, 1, 0, 1, 0, 'h8000, 1);
    vt[8]  = mk(0, 0, 0, 0, 0, 0, 1, -1, 0, 0);
    vt[9]  = mk(0, 0, 0, 0, 0, 0, 1,  0, 'hFFFF, 0);
    vt[10] = mk(0, 0, 0, 0, 0, 0, 1,  0, 'hFFFF, 0);
    vt[11] = mk(0, 0, 0, 0, 0, 0, 1,  0, 'h0000, 0);
    vt[12] = mk(0, 0, 0, 0, 0, 0, 1,  0, 'h0000, 0);
    vt[13] = mk(0, 0, 0, 0, 0, 0, 1,  0, 'hFFFF, 0);
    vt[14] = mk(1, 1, ADDR_STEP, 32'h4000_0000, 0, 0, 1, 1, 'h8000, 0);
    vt[15] = mk(1, 1, ADDR_CTRL, 32'h6, 0, 0, 1, 1, 'h8000, 0);
    vt[16] = mk(1, 1, ADDR_PHASE, 32'h8000_0000, 1, 0, 1, 1, 'h8000, 1);
    vt[17] = mk(0, 0, 0, 0, 0, 0, 1, -1, 0, 0);
    vt[18] = mk(0, 0, 0, 0, 0, 0, 1,  1, 'hFFFF, 0);
    vt[19] = mk(0, 0, 0, 0, 0, 0, 1,  1, 'h7FFF, 0);
    vt[20] = mk(0, 0, 0, 0, 0, 0, 1,  1, 'h0000, 0);
    vt[21] = mk(0, 0, 0, 0, 0, 0, 1,  1, 'h8000, 0);
    vt[22] = mk(1, 0, ADDR_DUTY, 32'h4000_0000, 0, 0, 1, -1, 0, 0);
    vt[23] = mk(1, 0, ADDR_STEP, 32'h1000_0000, 0, 0, 1, -1, 0, 0);
    vt[24] = mk(1, 0, ADDR_CTRL, 32'h7, 1, 1, 1, -1, 0, 1);
    vt[25] = mk(0, 0, 0, 0, 0, 0, 1, -1, 0, 0);
    vt[26] = mk(0, 0, 0, 0, 0, 0, 1,  0, 'hFFFF, 0);
    vt[27] = mk(0, 0, 0, 0, 0, 0, 1,  0, 'hFFFF, 0);
    vt[28] = mk(0, 0, 0, 0, 0, 0, 1,  0, 'hFFFF, 0);
    vt[29] = mk(0, 0, 0, 0, 0, 0, 1,  0, 'hFFFF, 0);
    vt[30] = mk(0, 0, 0, 0, 0, 0, 1,  0, 'h0000, 0);
    vt[31] = mk(0, 0, 0, 0, 0, 0, 1,  0, 'h0000, 0);

    for (int i = 0; i < 32; i++) begin
      drive(vt[i].we, vt[i].ch, vt[i].addr, vt[i].data, vt[i].cm, vt[i].clr, vt[i].rst);
      cycle();
      if (vt[i].chk >= 0)
        check($sformatf("vec%0d wave ch%0d", i, vt[i].chk), 64'(chWave(vt[i].chk)), 64'(vt[i].exp));
      if (vt[i].expAck >= 0)
        check($sformatf("vec%0d commit_ack", i), 64'(commitAck), 64'(vt[i].expAck));
    end

    // PWM at 25 % duty: any 16 consecutive samples hold exactly 4 highs
    idle();
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (chWave(0) == 'hFFFF) cnt++;
    end
    check("pwm high count", 64'(cnt), 64'd4);

    // DUTY=0 gives a constant low output
    drive(1, 0, ADDR_DUTY, 0, 1, 0, 1);
    cycle();
    idle();
    cycle();
    cycle();
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (chWave(0) != 0) cnt++;
    end
    check("pwm duty0 nonzero count", 64'(cnt), 64'd0);

    // Sine at quarter-turn steps, restarted from phase 0
    sineSeq = '{'h8000, 'hFFFF, 'h8000, 'h0001};
    drive(1, 0, ADDR_STEP, 32'h4000_0000, 0, 0, 1);
    cycle();
    drive(1, 0, ADDR_CTRL, 32'h4, 1, 1, 1);
    cycle();
    idle();
    cycle();
    for (int i = 0; i < 4; i++) begin
      cycle();
      check($sformatf("sine seq %0d", i), 64'(chWave(0)), 64'(sineSeq[i]));
    end

    // sync_clr with commit of a new STEP: both channels restart together
    drive(1, 0, ADDR_STEP, 32'h2000_0000, 0, 0, 1);
    cycle();
    drive(0, 0, 2'd0, 0, 1, 1, 1);
    cycle();
    idle();
    cycle();
    cycle();
    check("clr ch0 phase0", 64'(chWave(0)), 64'h8000);
    check("clr ch1 phase0", 64'(chWave(1)), 64'hFFFF);
    cycle();
    check("clr ch0 new step", 64'(chWave(0)), 64'hDA82);
    check("clr ch1 next", 64'(chWave(1)), 64'h7FFF);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            $urandom(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 99) != 0));
      cycle();
    end

    // Reset mid-stream overrides a simultaneous commit
    drive(1, 0, ADDR_CTRL, 32'h5, 1, 0, 0);
    cycle();
    check("rst wave", 64'(waveOut), 64'd0);
    check("rst valid", 64'(outValid), 64'd0);
    check("rst ack", 64'(commitAck), 64'd0);
    idle();
    cycle();
    check("rst valid +1", 64'(outValid), 64'd0);
    cycle();
    check("rst valid +2", 64'(outValid), 64'd1);
    check("rst default ch0", 64'(chWave(0)), 64'h8000);

    // Write to a channel index beyond NUM_CH is dropped
    drive(1, 3, ADDR_STEP, 32'h4000_0000, 0, 0, 1);
    cycle();
    drive(1, 3, ADDR_CTRL, 32'h5, 1, 0, 1);
    cycle();
    idle();
    for (int i = 0; i < 3; i++) cycle();
    for (int i = 0; i < 4; i++) begin
      cycle();
      check($sformatf("bad ch no change %0d", i), 64'(waveOut), {16'h0, {3{16'h8000}}});
    end

    // Disabled channel sits at midscale even with a rectangle programmed
    drive(1, 0, ADDR_STEP, 32'h4000_0000, 0, 0, 1);
    cycle();
    drive(1, 0, ADDR_CTRL, 32'h1, 1, 0, 1);
    cycle();
    idle();
    for (int i = 0; i < 3; i++) cycle();
    for (int i = 0; i < 4; i++) begin
      cycle();
      check($sformatf("disabled midscale %0d", i), 64'(chWave(0)), 64'h8000);
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
